// File: rtl/aes_decryption_192_iter_pkg.sv
// aes_192_pkg: shared constants, FSM state type and byte-level helpers
// for the iterative AES-192 decryption core.
//   sbox / inv_sbox : forward (key expansion) and inverse (rounds) S-box
//   xtime / gmul    : GF(2^8) arithmetic, reduction polynomial 0x11B
//   sub_word        : SubWord applied to a 32-bit key word
package aes_192_pkg;

    localparam int NK      = 6;
    localparam int NR      = 12;
    localparam int NW      = 52;
    // Each expansion step produces NK words; 8 steps cover w6..w53.
    localparam int KX_LAST = 8;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsm_e;

    localparam logic [0:7][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08,
                                        8'h10, 8'h20, 8'h40, 8'h80};

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; the multiplier is consumed LSB first.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        logic [7:0] m;
        acc = 8'h00;
        p   = a;
        m   = b;
        for (int i = 0; i < 8; i++) begin
            if (m[0]) acc = acc ^ p;
            p = xtime(p);
            m = m >> 1;
        end
        return acc;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round.
//   state_i    : current 128-bit state (byte 0 in bits 127:120)
//   rk_i       : round key for this round
//   rk_first_i : last round key, pre-XORed when first_i is set
//   first_i    : first inverse round (adds rk12 before the round)
//   last_i     : final round (InvMixColumns skipped)
//   state_o    : resulting state
module aes_inv_round
    import aes_192_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic [127:0] rk_first_i,
    input  logic         first_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    localparam logic [0:3][7:0] IMC = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    logic [127:0] t;
    logic [7:0]   a [16];
    logic [7:0]   m [16];

    assign t = first_i ? (state_i ^ rk_first_i) : state_i;

    // Byte (row r, column c) lives at index 4c+r. InvShiftRows pulls
    // row r from column (c - r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            localparam int DST = 4 * c + r;
            assign a[DST] = inv_sbox(t[127 - 8*SRC -: 8]) ^ rk_i[127 - 8*DST -: 8];
            assign m[DST] = gmul(a[4*c],     IMC[(4 - r) % 4]) ^
                            gmul(a[4*c + 1], IMC[(5 - r) % 4]) ^
                            gmul(a[4*c + 2], IMC[(6 - r) % 4]) ^
                            gmul(a[4*c + 3], IMC[(7 - r) % 4]);
            assign state_o[127 - 8*DST -: 8] = last_i ? a[DST] : m[DST];
        end
    end

endmodule

// File: rtl/aes_decryption_192_iter.sv
// aes_decryption_192_iter: iterative AES-192 decryption, one inverse round
// per clock, with the expanded key cached across blocks under one key.
//   CLK, RST                  : clock, synchronous active-high reset
//   IN_VALID / IN_READY       : ciphertext + key handshake
//   ENCRYPTED_DATA [0:127]    : ciphertext, bit 0 = MSB of byte 0
//   CIPHER_KEY     [0:191]    : cipher key, same byte order
//   OUT_VALID / OUT_READY     : plaintext handshake
//   DECRYPTED_DATA [0:127]    : plaintext, held while OUT_VALID
//
// state  | meaning
// IDLE   | waiting for a block; key compared against cache on accept
// KEYEXP | expanding 6 key words per cycle, cnt = iteration 1..8
// ROUND  | one inverse round per cycle, cnt = round index 11..0
// DONE   | result presented until OUT_READY
module aes_decryption_192_iter
    import aes_192_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [0:127] ENCRYPTED_DATA,
    input  logic [0:191] CIPHER_KEY,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [0:127] DECRYPTED_DATA
);

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         cache_valid_q, cache_valid_d;
    logic [127:0] blk_q, dout_q;
    logic [31:0]  w_q [NW];

    logic [127:0] ct_in;
    logic [191:0] key_in, key_cached;
    logic         accept, key_hit;
    logic [3:0]   kx_j;
    logic [5:0]   kx_base;
    logic [2:0]   rc_idx;
    logic [31:0]  kx_rot;
    logic [31:0]  kx_w0, kx_w1, kx_w2, kx_w3, kx_w4, kx_w5;
    logic [5:0]   rk_base;
    logic [127:0] rk_cur, rk_last, round_out;

    assign ct_in      = ENCRYPTED_DATA;
    assign key_in     = CIPHER_KEY;
    assign key_cached = {w_q[0], w_q[1], w_q[2], w_q[3], w_q[4], w_q[5]};

    assign IN_READY       = (fsm_q == IDLE) && !RST;
    assign accept         = IN_VALID && IN_READY;
    assign key_hit        = cache_valid_q && (key_in == key_cached);
    assign OUT_VALID      = (fsm_q == DONE);
    assign DECRYPTED_DATA = dout_q;

    // Outside KEYEXP the step index is pinned to 1 so the word reads stay in range.
    assign kx_j    = (fsm_q == KEYEXP) ? cnt_q : 4'd1;
    assign kx_base = 6'(NK) * {2'b00, kx_j};
    assign rc_idx  = 3'(kx_j - 4'd1);
    assign kx_rot  = {w_q[kx_base - 6'd1][23:0], w_q[kx_base - 6'd1][31:24]};
    assign kx_w0   = w_q[kx_base - 6'd6] ^ sub_word(kx_rot) ^ {RCON[rc_idx], 24'h000000};
    assign kx_w1   = w_q[kx_base - 6'd5] ^ kx_w0;
    assign kx_w2   = w_q[kx_base - 6'd4] ^ kx_w1;
    assign kx_w3   = w_q[kx_base - 6'd3] ^ kx_w2;
    assign kx_w4   = w_q[kx_base - 6'd2] ^ kx_w3;
    assign kx_w5   = w_q[kx_base - 6'd1] ^ kx_w4;

    assign rk_base = {cnt_q, 2'b00};
    assign rk_cur  = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    assign rk_last = {w_q[48], w_q[49], w_q[50], w_q[51]};

    aes_inv_round u_round (
        .state_i    (blk_q),
        .rk_i       (rk_cur),
        .rk_first_i (rk_last),
        .first_i    (cnt_q == 4'(NR - 1)),
        .last_i     (cnt_q == 4'd0),
        .state_o    (round_out)
    );

    always_comb begin
        fsm_d         = fsm_q;
        cnt_d         = cnt_q;
        cache_valid_d = cache_valid_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    if (key_hit) begin
                        fsm_d = ROUND;
                        cnt_d = 4'(NR - 1);
                    end else begin
                        fsm_d         = KEYEXP;
                        cnt_d         = 4'd1;
                        cache_valid_d = 1'b0;
                    end
                end
            end
            KEYEXP: begin
                if (cnt_q == 4'(KX_LAST)) begin
                    fsm_d         = ROUND;
                    cnt_d         = 4'(NR - 1);
                    cache_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                if (cnt_q == 4'd0) fsm_d = DONE;
                else               cnt_d = cnt_q - 4'd1;
            end
            DONE: begin
                if (OUT_READY) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q         <= IDLE;
            cnt_q         <= 4'd0;
            cache_valid_q <= 1'b0;
            blk_q         <= '0;
            dout_q        <= '0;
        end else begin
            fsm_q         <= fsm_d;
            cnt_q         <= cnt_d;
            cache_valid_q <= cache_valid_d;
            if (accept)              blk_q <= ct_in;
            else if (fsm_q == ROUND) blk_q <= round_out;
            if (fsm_q == ROUND && cnt_q == 4'd0) dout_q <= round_out;
        end
    end

    // Key words are not reset; cache_valid_q alone decides whether they are trusted.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (accept) begin
                w_q[0] <= key_in[191:160];
                w_q[1] <= key_in[159:128];
                w_q[2] <= key_in[127:96];
                w_q[3] <= key_in[95:64];
                w_q[4] <= key_in[63:32];
                w_q[5] <= key_in[31:0];
            end else if (fsm_q == KEYEXP) begin
                w_q[kx_base]        <= kx_w0;
                w_q[kx_base + 6'd1] <= kx_w1;
                w_q[kx_base + 6'd2] <= kx_w2;
                w_q[kx_base + 6'd3] <= kx_w3;
                // The final step would produce w52/w53, which AES-192 never uses.
                if (kx_j != 4'(KX_LAST)) begin
                    w_q[kx_base + 6'd4] <= kx_w4;
                    w_q[kx_base + 6'd5] <= kx_w5;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_decryption_192_iter.sv
module tb_aes_decryption_192_iter;

    logic         CLK = 1'b0;
    logic         RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic [0:127] ENCRYPTED_DATA;
    logic [0:191] CIPHER_KEY;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [0:127] DECRYPTED_DATA;

    always #5 CLK = ~CLK;

    aes_decryption_192_iter dut (
        .CLK            (CLK),
        .RST            (RST),
        .IN_VALID       (IN_VALID),
        .IN_READY       (IN_READY),
        .ENCRYPTED_DATA (ENCRYPTED_DATA),
        .CIPHER_KEY     (CIPHER_KEY),
        .OUT_VALID      (OUT_VALID),
        .OUT_READY      (OUT_READY),
        .DECRYPTED_DATA (DECRYPTED_DATA)
    );

    localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] PT_C2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] KEY_SP = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] CT_SP1 = 128'hbd334f1d6e45f25ff712a214571fa5cc;
    localparam logic [127:0] PT_SP1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_SP2 = 128'h974104846d0ad3ad7734ecb3ecee4eef;
    localparam logic [127:0] PT_SP2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    typedef struct {
        logic [127:0] pt;
        int           acc;
        int           lat;
        int           id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   outs   = 0;
    logic ov_prev = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation each time OUT_VALID rises.
    always @(negedge CLK) begin
        if (OUT_VALID && !ov_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected no output", DECRYPTED_DATA);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("blk%0d_data", mon_e.id), DECRYPTED_DATA, mon_e.pt);
                check($sformatf("blk%0d_latency", mon_e.id), 128'(cyc - mon_e.acc), 128'(mon_e.lat));
            end
            outs++;
        end
        ov_prev = OUT_VALID;
    end

    // Called just after a falling edge; returns just after a falling edge.
    task automatic submit(input logic [191:0] key, input logic [127:0] ct, input logic [127:0] pt,
                          input int lat, input int id, input bit push, input bit garble);
        int   waited;
        exp_t e;
        waited         = 0;
        CIPHER_KEY     = key;
        ENCRYPTED_DATA = ct;
        IN_VALID       = 1'b1;
        while (!IN_READY && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        if (!IN_READY) begin
            checks++;
            errors++;
            $display("FAIL blk%0d_accept_timeout: got in_ready=0 expected 1", id);
            IN_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        if (push) begin
            e.pt  = pt;
            e.acc = cyc;
            e.lat = lat;
            e.id  = id;
            sb.push_back(e);
        end
        if (garble) begin
            ENCRYPTED_DATA = ~ct;
            CIPHER_KEY     = ~key;
        end
        @(negedge CLK);
    endtask

    task automatic wait_ready(input string name);
        int waited;
        waited = 0;
        while (!IN_READY && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        if (!IN_READY) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got in_ready=0 expected 1", name);
        end
    endtask

    initial begin
        int waited;
        RST            = 1'b1;
        IN_VALID       = 1'b0;
        OUT_READY      = 1'b1;
        ENCRYPTED_DATA = '0;
        CIPHER_KEY     = '0;
        repeat (3) @(negedge CLK);
        check("rst_in_ready", 128'(IN_READY), 128'd0);
        check("rst_out_valid", 128'(OUT_VALID), 128'd0);
        check("rst_dout", DECRYPTED_DATA, 128'd0);
        RST = 1'b0;
        #1;
        check("rel_in_ready", 128'(IN_READY), 128'd1);

        // FIPS-197 C.2, cold cache
        submit(KEY_C2, CT_C2, PT_C2, 20, 1, 1'b1, 1'b0);
        // SP800-38A back-to-back, second block hits the cache
        submit(KEY_SP, CT_SP1, PT_SP1, 20, 2, 1'b1, 1'b0);
        submit(KEY_SP, CT_SP2, PT_SP2, 12, 3, 1'b1, 1'b0);
        // Key switching: every change re-expands
        submit(KEY_C2, CT_C2, PT_C2, 20, 4, 1'b1, 1'b0);
        submit(KEY_SP, CT_SP1, PT_SP1, 20, 5, 1'b1, 1'b0);
        submit(KEY_C2, CT_C2, PT_C2, 20, 6, 1'b1, 1'b0);

        // Backpressure with an offered block that must not be taken
        wait_ready("pre_stall");
        OUT_READY = 1'b0;
        submit(KEY_C2, CT_C2, PT_C2, 12, 7, 1'b1, 1'b0);
        waited = 0;
        while (!OUT_VALID && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        check("stall_out_valid_arrives", 128'(OUT_VALID), 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            IN_VALID       = 1'b1;
            ENCRYPTED_DATA = CT_SP1;
            CIPHER_KEY     = KEY_SP;
            check($sformatf("stall%0d_dout", i), DECRYPTED_DATA, PT_C2);
            check($sformatf("stall%0d_in_ready", i), 128'(IN_READY), 128'd0);
            check($sformatf("stall%0d_out_valid", i), 128'(OUT_VALID), 128'd1);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("post_stall_out_valid", 128'(OUT_VALID), 128'd0);
        check("post_stall_in_ready", 128'(IN_READY), 128'd1);

        // Reset during ROUND of a cache-hit C.2 block; nothing may come out
        submit(KEY_C2, CT_C2, PT_C2, 0, 8, 1'b0, 1'b0);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("midrst_out_valid", 128'(OUT_VALID), 128'd0);
        check("midrst_dout", DECRYPTED_DATA, 128'd0);
        check("midrst_in_ready", 128'(IN_READY), 128'd1);
        submit(KEY_C2, CT_C2, PT_C2, 20, 9, 1'b1, 1'b0);

        // Inputs scrambled right after accept
        submit(KEY_SP, CT_SP2, PT_SP2, 20, 10, 1'b1, 1'b1);
        submit(KEY_SP, CT_SP1, PT_SP1, 12, 11, 1'b1, 1'b1);

        waited = 0;
        while ((sb.size() != 0 || !IN_READY) && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        check("output_count", 128'(outs), 128'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_decryption_192_iter.md
# aes_decryption_192_iter

- Iterative AES-192 decryption core that inverts the ciphertext produced by the AES-192 encryption path.
- Accepts a 128-bit ciphertext and a 192-bit cipher key over a valid/ready handshake.
- Expands the key once and caches it for back-to-back blocks under the same key.
- Runs one inverse round per clock and returns the plaintext over a second valid/ready handshake.

## Interface
Parameters: none. Fixed AES-192: Nk=6, Nr=12, 52 round-key words.

Ports:
- CLK  in  1  single clock; all logic on the rising edge
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  ciphertext/key offered
- IN_READY  out  1  core can accept a block
- ENCRYPTED_DATA  in  [0:127]  ciphertext; bit 0 is the MSB of byte 0
- CIPHER_KEY  in  [0:191]  cipher key; same big-endian byte order
- OUT_VALID  out  1  DECRYPTED_DATA holds a result
- OUT_READY  in  1  consumer takes the result
- DECRYPTED_DATA  out  [0:127]  plaintext

## Operation
States:
- IDLE: IN_READY=1. A handshake (IN_VALID & IN_READY) captures ENCRYPTED_DATA into the state register and CIPHER_KEY into the key register.
  - Go to ROUND if cache_valid=1 and CIPHER_KEY equals the cached key.
  - Otherwise clear cache_valid and go to KEYEXP.
- KEYEXP: 8 cycles, iteration j=1..8.
  - Each cycle generates words w[6j]..w[6j+5] from w[6j-6]..w[6j-1] via the FIPS-197 recurrence.
  - RotWord, SubWord and Rcon[j] are applied to the first word only. Rcon = 01,02,04,08,10,20,40,80.
  - Words 52..53 of iteration 8 are discarded.
  - After iteration 8: set cache_valid=1 and go to ROUND.
- ROUND: 12 cycles, round index r = 11 down to 0.
  - Compute t = state, XORed with rk12 when r=11.
  - Then t = InvSubBytes(InvShiftRows(t)) ^ rk[r].
  - Apply InvMixColumns when r≠0.
  - Register t into the state register.
  - After r=0: copy the state register to DECRYPTED_DATA and go to DONE.
- DONE: OUT_VALID=1. DECRYPTED_DATA is held stable. OUT_READY=1 → IDLE.

Other rules:
- IN_READY is high only in IDLE and only while RST=0. No new block is accepted while in DONE.
- Round key rk[i] is words w[4i]..w[4i+3].
- Round-key storage is 52×32-bit registers. It is written only in IDLE (w0..w5 from the key) and in KEYEXP.
- GF(2^8) arithmetic uses reduction polynomial 0x11B. InvMixColumns uses coefficients 0E,0B,0D,09.
- Inputs are sampled only at the accept edge. Later changes to ENCRYPTED_DATA or CIPHER_KEY have no effect on a block in flight.

## Timing
- Reset state: IDLE, IN_READY=0 while RST=1, OUT_VALID=0, DECRYPTED_DATA=0, cache_valid=0, round counter=0.
- RST during KEYEXP, ROUND or DONE:
  - Aborts the block with no output.
  - Invalidates the cache.
  - IN_READY=1 on the first cycle with RST=0.
- Latency is measured from accept edge E0 to the edge that raises OUT_VALID:
  - Cache miss: E0+20 (8 KEYEXP + 12 ROUND).
  - Cache hit: E0+12.
- OUT_VALID stays high until the edge where OUT_READY=1. If OUT_READY is already high on arrival, that is the next edge.
- IN_READY rises on the edge that completes the output handshake. Minimum issue interval for a cache hit: 14 cycles.
- Exactly one block is in flight at a time, so there is no overlap or overflow case.

## Structure
- Package aes_192_pkg holds:
  - Constants NK=6, NR=12, NW=52.
  - The state enum {IDLE, KEYEXP, ROUND, DONE}.
  - Rcon table.
  - Forward S-box function (used by key expansion) and inverse S-box function.
  - xtime and gmul functions.
- Sub-module aes_inv_round: combinational, with ports state, round key, first flag (pre-XOR rk12), last flag (skip InvMixColumns). Instantiated once.
- Key expansion step is inline in the top level.

## Test plan
- FIPS-197 C.2:
  - Key 000102030405060708090a0b0c0d0e0f1011121314151617, ciphertext dda97ca4864cdfe06eaf70a0ec0d7191.
  - Expect plaintext 00112233445566778899aabbccddeeff with OUT_VALID at E0+20.
- SP800-38A ECB-AES192 back-to-back:
  - Key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - Block 1: ciphertext bd334f1d6e45f25ff712a214571fa5cc → 6bc1bee22e409f96e93d7e117393172a at E0+20.
  - Block 2, same key: 974104846d0ad3ad7734ecb3ecee4eef → ae2d8a571e03ac9c9eb76fac45af8e51 at E0+12 (cache hit).
- Key switch: C.2 vector, then the SP800-38A vector, then C.2 again.
  - Each key change takes 20 cycles and all three results are correct.
- Backpressure: hold OUT_READY=0 for 10 cycles after OUT_VALID.
  - DECRYPTED_DATA stays stable and IN_READY stays 0.
  - Drive new ENCRYPTED_DATA with IN_VALID=1 during the stall; it is not accepted.
- Reset mid-run: assert RST for 1 cycle during ROUND of the C.2 vector.
  - OUT_VALID=0 and DECRYPTED_DATA=0.
  - Resubmitting the same key takes 20 cycles (cache invalidated) and the result is correct.
- Input change after accept: change ENCRYPTED_DATA and CIPHER_KEY on the cycle after accept.
  - Output still equals the plaintext for the captured block.
